// File: rtl/fnc_vramarbiter.sv
// Single-port VRAM arbiter: the display has absolute priority. CPU writes are posted through a
// one-entry buffer and CPU reads are queued; both drain into free cycles. Starvation is monitored.
module fnc_vramarbiter #(
    parameter int unsigned AW           = 19,
    parameter int unsigned DW           = 12,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          module_en,
    input  logic          disp_en,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_busy,
    output logic          cpu_starve,
    input  logic          starve_clr,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int unsigned   CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_PEND = 2'd1,
        ST_RD_DATA = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          rd_cnt_q, rd_cnt_d;
    logic          buf_full_q, buf_full_d;
    logic [AW-1:0] buf_addr_q;
    logic [DW-1:0] buf_data_q;
    logic [AW-1:0] rd_addr_q;
    logic [AW-1:0] ram_addr_q;
    logic          ram_we_q;
    logic [DW-1:0] ram_wdata_q;
    logic          disp_p1_q, disp_p2_q;
    logic          disp_valid_q;
    logic [DW-1:0] disp_data_q;
    logic          cpu_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic          cpu_busy_q;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_q, starve_d;

    logic slot_disp_c, slot_wr_c, slot_rd_c;
    logic wr_accept_c, rd_accept_c, rd_done_c;
    logic sample_c, pending_c;

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Read FSM next state; RD_DATA lasts two cycles while the RAM read returns
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_accept_c) state_d = ST_RD_PEND;
            end
            ST_RD_PEND: begin
                if (slot_rd_c) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (rd_cnt_q) state_d = ST_IDLE;
                else          rd_cnt_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot arbitration and request acceptance
    always_comb begin
        slot_disp_c = module_en & disp_en;
        slot_wr_c   = ~slot_disp_c & buf_full_q;
        slot_rd_c   = ~slot_disp_c & ~buf_full_q & (state_q == ST_RD_PEND);
        sample_c    = (state_q == ST_IDLE) & cpu_req & ~cpu_ack_q;
        wr_accept_c = sample_c & cpu_we & ~buf_full_q;
        rd_accept_c = sample_c & ~cpu_we;
        rd_done_c   = (state_q == ST_RD_DATA) & rd_cnt_q;
    end

    // Write buffer occupancy and starvation counter next values
    always_comb begin
        buf_full_d   = wr_accept_c | (buf_full_q & ~slot_wr_c);
        pending_c    = buf_full_q | (state_q == ST_RD_PEND);
        starve_cnt_d = starve_cnt_q;
        if (starve_clr || slot_wr_c || slot_rd_c) begin
            starve_cnt_d = '0;
        end else if (pending_c && slot_disp_c && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
        starve_d = ~starve_clr & (starve_q | (starve_cnt_d == STARVE_MAX));
    end

    // Datapath registers: RAM port, read pipelines, CPU handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full_q   <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            rd_addr_q    <= '0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            disp_p1_q    <= 1'b0;
            disp_p2_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            cpu_busy_q   <= 1'b0;
            starve_cnt_q <= '0;
            starve_q     <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            if (wr_accept_c) begin
                buf_addr_q <= cpu_addr;
                buf_data_q <= cpu_wdata;
            end
            if (rd_accept_c) rd_addr_q <= cpu_addr;

            ram_we_q <= slot_wr_c;
            if (slot_disp_c) begin
                ram_addr_q <= disp_addr;
            end else if (slot_wr_c) begin
                ram_addr_q  <= buf_addr_q;
                ram_wdata_q <= buf_data_q;
            end else if (slot_rd_c) begin
                ram_addr_q <= rd_addr_q;
            end

            disp_p1_q    <= slot_disp_c;
            disp_p2_q    <= disp_p1_q;
            disp_valid_q <= disp_p2_q;
            if (disp_p2_q) disp_data_q <= ram_rdata;

            cpu_ack_q <= wr_accept_c | rd_done_c;
            if (rd_done_c) cpu_rdata_q <= ram_rdata;
            cpu_busy_q <= buf_full_d | (state_d != ST_IDLE);

            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign cpu_ack    = cpu_ack_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_busy   = cpu_busy_q;
    assign cpu_starve = starve_q;
    assign ram_addr   = ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: doc/fnc_vramarbiter.md
# fnc_vramarbiter

Single-port VRAM arbiter between the VGA scanout path and the CPU bus-side VRAM port. The display has absolute priority on every cycle it requests. CPU writes are posted through a one-entry write buffer, and CPU reads are queued, so both drain into cycles the display leaves free (blanking). All RAM-side signals are registered. A starvation monitor flags CPU traffic that the display locks out for too long.

## Interface
- AW, 19, VRAM address width
- DW, 12, pixel/data width
- STARVE_LIMIT, 1024, blocked-cycle count that sets cpu_starve
- clk  in  1  single clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- module_en  in  1  display request enable; 0 = display slots suppressed
- disp_en  in  1  display read request this cycle
- disp_addr  in  AW  display read address
- disp_valid  out  1  display read data valid
- disp_data  out  DW  display read data
- cpu_req  in  1  CPU request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion/accept pulse
- cpu_rdata  out  DW  read data, valid with cpu_ack of a read
- cpu_busy  out  1  write buffer full or read outstanding
- cpu_starve  out  1  sticky starvation flag
- starve_clr  in  1  clears cpu_starve and the starve counter
- ram_addr  out  AW  RAM address (registered)
- ram_we  out  1  RAM write strobe (registered)
- ram_wdata  out  DW  RAM write data (registered)
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_addr

## Operation
- Slot decision each cycle, priority order:
  1. Display when module_en & disp_en.
  2. Else write, when the write buffer is full.
  3. Else read, when the read FSM is in RD_PEND.
  4. Else idle: ram_we=0 and ram_addr holds its value.
- Write posting:
  - A write is accepted in IDLE when cpu_req & cpu_we, the buffer is empty and cpu_ack=0.
  - The buffer captures addr/wdata and cpu_ack pulses the next cycle.
  - A write arriving while the buffer is full waits without ack.
- Read FSM states:
  - IDLE -> RD_PEND on cpu_req & ~cpu_we & cpu_ack=0. The request is sampled even when the buffer is full.
  - RD_PEND -> RD_DATA when the read slot is granted. Reads never pass a buffered write: the buffer drains first.
  - RD_DATA -> IDLE after two cycles, with cpu_ack and cpu_rdata.
- CPU requests are not sampled in a cycle with cpu_ack=1, so a held request is never double-accepted.
- Requests are ignored while the state is not IDLE. A read and a write are never accepted in the same cycle.
- cpu_busy = buffer_full | (state != IDLE).
- Starvation monitor:
  - The counter (width clog2(STARVE_LIMIT+1), saturating) increments each cycle a CPU operation is pending and a display slot is taken.
  - It clears on any CPU slot.
  - When it reaches STARVE_LIMIT, cpu_starve sets.
  - starve_clr clears the flag and the counter, and wins over a same-cycle set.
- When module_en goes low, display reads already in flight still complete with disp_valid. No new display slots are granted.

## Timing
- Reset: every output is 0, buffer empty, FSM IDLE, counter 0.
- Reset mid-operation drops buffered and pending operations, with no ack and no RAM write.
- Display slot at cycle t:
  - ram_addr=disp_addr, ram_we=0 at t+1
  - ram_rdata at t+2
  - disp_valid=1 and disp_data registered at t+3
  - Fixed latency 3, full throughput, one read per cycle.
- CPU write accepted at t: cpu_ack at t+1. Drain slot g: ram_we=1 at g+1 and buffer empty from g+1. The earliest next write accept is g+1, with ack at g+2.
- CPU read slot g: ram_addr at g+1, cpu_ack=1 with cpu_rdata at g+3.
- Unblocked latency is 4 cycles from request sample to ack (t -> RD_PEND t+1 -> slot t+1 -> ack t+4).
- ram_we is high for exactly one cycle per buffered write.
- No display slot is ever delayed or dropped.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0 and no ram_we.
- disp_en=1 for 640 cycles, addr 0..639, with RAM modelled as data=addr[11:0] -> disp_valid for 640 cycles starting 3 cycles after the first disp_en, disp_data=0..639.
- disp_en=1 and a CPU write (0x100, 0xABC) arrives -> cpu_ack after 1 cycle, no ram_we until disp_en drops. ram_we with addr 0x100 and data 0xABC comes 1 cycle after the first free cycle.
- Write 0x200=0x123 immediately followed by a read of 0x200 with the display idle -> the write drains before the read slot, and the read ack returns cpu_rdata=0x123.
- STARVE_LIMIT=8, a read held pending against continuous disp_en -> cpu_starve=1 after 8 blocked cycles and stays set. starve_clr=1 clears it. The read completes after disp_en drops.
- rst=1 asserted with a write buffered and a read in RD_PEND -> no cpu_ack, no ram_we, all outputs 0 the next cycle.
